// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared types, segment glyphs and sizing helper for bin_to_bcd_7seg_seq
package bin_to_bcd_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Segment glyphs, bit order gfedcba, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Number of decimal digits needed to show the largest width-bit unsigned value
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    int              d;
    max_val = (64'd1 << width) - 64'd1;
    d       = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_to_seg7.sv
// rtl/bcd_digit_to_seg7.sv - combinational single BCD digit to 7-segment (gfedcba) decoder
module bcd_digit_to_seg7
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup; non-decimal codes show nothing
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_bcd_7seg_seq.sv
// rtl/bin_to_bcd_7seg_seq.sv - sequential double-dabble binary to BCD + 7-segment driver; option macro BIN_TO_BCD_LEADING_ZERO_BLANK_EN
module bin_to_bcd_7seg_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_7seg_seq: WIDTH must be in 1..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_7seg_seq: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [WIDTH-1:0]   shreg_shift;
  logic [SEG_W-1:0]   seg_raw;
  logic [SEG_W-1:0]   seg_disp;

  // One double-dabble step: add 3 to every digit >= 5, then shift scratch:value left
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_shift, shreg_shift} = {scratch_adj, shreg_q} << 1;
  end

  // Decode the post-step digits so the final step can load seg on the same edge as bcd
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_to_seg7 u_dec (
      .digit (scratch_shift[4*g +: 4]),
      .seg   (seg_raw[7*g +: 7])
    );
  end

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Blank zero digits above the most significant non-zero digit; digit 0 always shows
  always_comb begin
    seg_disp = seg_raw;
    seen_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_shift[4*i +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      if (!seen_nz) begin
        seg_disp[7*i +: 7] = SEG_BLANK;
      end
    end
  end
`else
  assign seg_disp = seg_raw;
`endif

  // Sequencer next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    seg_d       = seg_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = in_data;
          scratch_d  = '0;
          cnt_d      = CNT_W'(WIDTH);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift;
        shreg_d   = shreg_shift;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d       = scratch_shift;
          seg_d       = seg_disp;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      seg_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      seg_q       <= seg_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign seg       = seg_q;

endmodule

// File: doc/bin_to_bcd_7seg_seq.md
Name: bin_to_bcd_7seg_seq

Overview:
- Sequential, parametrised binary-to-decimal display driver.
- Accepts a WIDTH-bit unsigned value over a valid/ready handshake and converts it to DIGITS packed BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Presents both the BCD result and per-digit 7-segment patterns (gfedcba, active-high) over a second valid/ready handshake.
- Replaces the fixed 8-bit lookup-table split and the single-digit decoder that feed the hex displays.

Parameters:
- WIDTH, 8, input value width in bits; legal range 1..32.
- DIGITS, 3, number of decimal digits produced. Must satisfy 10^DIGITS > 2^WIDTH-1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a value.
- in_data  in  WIDTH  unsigned binary value.
- out_valid  out  1  bcd/seg hold a completed result.
- out_ready  in  1  consumer accepts result.
- bcd  out  4*DIGITS  packed BCD; digit i at [4i+3:4i], digit 0 is least significant.
- seg  out  7*DIGITS  segment patterns; digit i at [7i+6:7i], bit order gfedcba.

Behaviour:
- Reset (async, any state, including mid-conversion):
  - FSM goes to IDLE and any in-flight conversion is discarded.
  - out_valid=0, bcd=0, seg=0 (all blank).
  - Shift register, scratch digits and counter are cleared.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_data into the shift register, clear the scratch BCD, set counter=WIDTH, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, every scratch digit >=5 gets +3 (4-bit add, no carry out). Then {scratch, shift register} shifts left one bit. Counter decrements.
  - When the counter goes 1->0, load the final scratch into bcd and its decoded patterns into seg on the same edge, assert out_valid, and go to DONE.
- DONE:
  - in_ready=0. out_valid=1. bcd and seg are stable.
  - On an edge with out_ready=1: clear out_valid and go to IDLE.
  - bcd and seg keep their last value until the next result loads. They are never cleared except by reset.
- Latency and throughput:
  - out_valid rises exactly WIDTH clock edges after the accepting edge.
  - One bubble cycle (IDLE) occurs between results, so throughput is one result per WIDTH+2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and outputs are stable for as long as out_ready=0. in_valid is ignored outside IDLE.
- Simultaneous events: in_valid during DONE with out_ready=1 is not accepted on that edge; it is taken on the following IDLE cycle.
- Decode:
  - Digits 0-9 map to the standard glyphs: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111.
  - Codes 10-15 cannot occur; decode them to blank (0000000).
- Boundaries:
  - in_data=0 yields all digits 0.
  - in_data=2^WIDTH-1 must convert exactly.
  - WIDTH=1 converts in a single SHIFT cycle.

Optional Feature:
- Macro: BIN_TO_BCD_LEADING_ZERO_BLANK_EN.
- When defined: seg for every zero digit above the most significant non-zero digit is 0000000. Digit 0 is always displayed, so the value 0 shows a single "0". bcd is unaffected.
- When not defined: all DIGITS positions are displayed, leading zeros included.

Decomposition:
- Package bin_to_bcd_pkg contains:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - A constant function returning the minimum legal DIGITS for a given WIDTH, used by the elaboration check.
- Sub-module bcd_digit_to_seg7: combinational 4-bit BCD to 7-segment decoder, instantiated DIGITS times via generate.

Test Plan:
- Zero input: WIDTH=8, DIGITS=3, in_data=0 accepted, out_ready=1 -> out_valid exactly 8 edges later; bcd=12'h000; seg = three copies of 0111111 (macro off), or blank, blank, 0111111 (macro on).
- Full-scale 8-bit: in_data=255 -> bcd=12'h255; seg digit2=1011011, digit1=1101101, digit0=1101101.
- Backpressure: in_data=128 with out_ready=0 for 20 cycles -> out_valid held, bcd=12'h128 stable, in_ready=0 throughout; drive in_data=7 with in_valid during the stall -> ignored. Raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 3 cycles after accepting 200 -> out_valid=0, bcd=0, seg=0, in_ready=1 immediately. A following in_data=42 -> bcd=12'h042.
- Wide configuration: WIDTH=16, DIGITS=5, in_data=65535 -> bcd=20'h65535, out_valid 16 edges after accept. Back-to-back inputs 1 and 9999 -> 18-cycle spacing between results.
- Leading-zero blanking (macro on): WIDTH=8, in_data=7 -> seg = 0000000, 0000000, 0000111; in_data=105 -> all three digits displayed.
